// File: rtl/zuc_pkg.sv
// ZUC v1.6 shared types, S-box tables and arithmetic helpers.
// Mod (2^31-1) arithmetic uses end-around carry on 31-bit words.
package zuc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_DISC,
    ST_RUN
  } zuc_st_e;

  typedef logic [15:0][30:0] lfsr_t;

  localparam logic [4:0]  LAST_RND = 5'd31;
  localparam logic [30:0] P31      = 31'h7fffffff;

  localparam logic [0:255][7:0] S0_TAB = {
    128'h3e725b47cae0003304d1549809b96dcb,
    128'h7b1bf932af9d6aa5b82dfc1d08530390,
    128'h4d4e8499e4ced991ddb685488b296eac,
    128'hcdc1f81e734369c6b5bdfd396320d438,
    128'h767db2a7cfed57c5f32cbb142106559b,
    128'he3ef5e314f7f5aa40d8251495fba581c,
    128'h4a16d517a892241f8cffd8ae2e01d3ad,
    128'h3b4bda46ebc9de9a8f87d73a806f2fc8,
    128'hb1b437f70a2213287ccc3c89c7c39656,
    128'h07bf7ef00b2b975235417961a64c10fe,
    128'hbc2695888ab0a3fbc01894f2e1e5e95d,
    128'hd0dc1166645cec59427512f5749caa23,
    128'h0e86abbe2a02e767e644a26cc2939ff1,
    128'hf6fa36d250689e6271153dd640c4e20f,
    128'h8e83776b25053f0c30ea70b7a1e8a965,
    128'h8d271adb81b3a0f4457a19dfee783460
  };

  localparam logic [0:255][7:0] S1_TAB = {
    128'h55c263713bc847869f3cda5b29aafd77,
    128'h8cc5940ca61a1300e3a8167240f9f842,
    128'h4426689681d9453e1076c6a78b3943e1,
    128'h3ab5562ac06db3052266bfdc0bfa6248,
    128'hdd20110636c9c1cff62752bb69f5d487,
    128'h7f844cd29c57a4bc4f9adffed68d7aeb,
    128'h2b53d85ca11417fb23d57d3067730809,
    128'heeb7703f61b2198e4ee54b938f5ddba9,
    128'hadf1ae2ecb0dfcf42d466e1d97e8d1e9,
    128'h4d37a5755e839eab829db91ce0cd4989,
    128'h01b6bd5824a25f387899159050b895e4,
    128'hd091c7ceed0fb46fa0ccf0024a79c3de,
    128'ha3efea51e66b18ec1b2c80f774e7ff21,
    128'h5a6a541e41319235c433070aba7e0e34,
    128'h88b1987cf33d606c7bcad31f32650428,
    128'h64be859b2f598ad7b025acaf1203e2f2
  };

  localparam logic [0:15][14:0] D_TAB = {
    15'h44D7, 15'h26BC, 15'h626B, 15'h135E,
    15'h5789, 15'h35E2, 15'h7135, 15'h09AF,
    15'h4D78, 15'h2F13, 15'h6BC4, 15'h1AF1,
    15'h5E26, 15'h3C4D, 15'h789A, 15'h47AC
  };

  function automatic logic [30:0] add31(
    input logic [30:0] a,
    input logic [30:0] b
  );
    logic [31:0] s;
    logic [31:0] t;
    s = {1'b0, a} + {1'b0, b};
    t = {1'b0, s[30:0]} + {31'd0, s[31]};
    return t[30:0];
  endfunction

  function automatic logic [30:0] rot31(
    input logic [30:0] x,
    input int          k
  );
    return (x << k) | (x >> (31 - k));
  endfunction

  function automatic logic [31:0] rol32(
    input logic [31:0] x,
    input int          k
  );
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] l1(input logic [31:0] x);
    return x ^ rol32(x, 2) ^ rol32(x, 10)
             ^ rol32(x, 18) ^ rol32(x, 24);
  endfunction

  function automatic logic [31:0] l2(input logic [31:0] x);
    return x ^ rol32(x, 8) ^ rol32(x, 14)
             ^ rol32(x, 22) ^ rol32(x, 30);
  endfunction

  function automatic logic [31:0] s_fn(input logic [31:0] x);
    return {S0_TAB[x[31:24]], S1_TAB[x[23:16]],
            S0_TAB[x[15:8]],  S1_TAB[x[7:0]]};
  endfunction

  function automatic logic [30:0] lfsr_fb(input lfsr_t s);
    logic [30:0] a;
    a = add31(rot31(s[15], 15), rot31(s[13], 17));
    a = add31(a, rot31(s[10], 21));
    a = add31(a, rot31(s[4], 20));
    a = add31(a, rot31(s[0], 8));
    a = add31(a, s[0]);
    return a;
  endfunction

endpackage

// File: rtl/zuc_keystream_gen_sbox.sv
// 32-bit S-transform for the R1/R2 update paths.
// With sync set the result is taken from a register one clock later.
module zuc_sbox
  import zuc_pkg::*;
#(
  parameter bit sync = 1'b0
) (
  input  logic        clk,
  input  logic [31:0] u_i,
  input  logic [31:0] v_i,
  output logic [31:0] su_o,
  output logic [31:0] sv_o
);

  logic [31:0] su_c;
  logic [31:0] sv_c;
  logic [31:0] su_q;
  logic [31:0] sv_q;

  assign su_c = s_fn(u_i);
  assign sv_c = s_fn(v_i);

  always_ff @(posedge clk) begin
    su_q <= su_c;
    sv_q <= sv_c;
  end

  assign su_o = sync ? su_q : su_c;
  assign sv_o = sync ? sv_q : sv_c;

endmodule

// File: rtl/zuc_keystream_gen.sv
// ZUC keystream generator: key/IV load, 32 init rounds, one
// discarded work step, then a valid/ready stream of 32-bit words.
module zuc_keystream_gen
  import zuc_pkg::*;
#(
  parameter bit sbox_sync = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_init,
  input  logic [127:0] s_key,
  input  logic [127:0] s_iv,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data
);

  zuc_st_e     st_q, st_d;
  lfsr_t       lfsr_q, lfsr_d, lfsr_ld;
  logic [31:0] r1_q, r1_d, r2_q, r2_d;
  logic [31:0] z_q, z_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        ph_q, ph_d;
  logic        mv_q, mv_d;

  logic [31:0] x0, x1, x2, x3;
  logic [31:0] w, w1, w2, u, v;
  logic [31:0] su, sv;
  logic [30:0] fb_v, fb_i, s16;
  logic        load, step;

  assign x0 = {lfsr_q[15][30:15], lfsr_q[14][15:0]};
  assign x1 = {lfsr_q[11][15:0],  lfsr_q[9][30:15]};
  assign x2 = {lfsr_q[7][15:0],   lfsr_q[5][30:15]};
  assign x3 = {lfsr_q[2][15:0],   lfsr_q[0][30:15]};

  assign w  = (x0 ^ r1_q) + r2_q;
  assign w1 = r1_q + x1;
  assign w2 = r2_q ^ x2;
  assign u  = l1({w1[15:0], w2[31:16]});
  assign v  = l2({w2[15:0], w1[31:16]});

  zuc_sbox #(
    .sync (sbox_sync)
  ) u_sbox (
    .clk  (clk),
    .u_i  (u),
    .v_i  (v),
    .su_o (su),
    .sv_o (sv)
  );

  assign fb_v = lfsr_fb(lfsr_q);
  assign fb_i = (st_q == ST_INIT) ? add31(fb_v, w[31:1]) : fb_v;
  assign s16  = (fb_i == 31'd0) ? P31 : fb_i;

  assign s_ready = (st_q == ST_IDLE) || (st_q == ST_RUN);
  assign load    = s_valid && s_ready && s_init;
  assign m_valid = mv_q;
  assign m_data  = z_q;

  always_comb begin
    for (int i = 0; i < 16; i++)
      lfsr_ld[i] = {s_key[8*i +: 8], D_TAB[i], s_iv[8*i +: 8]};
  end

  // In RUN a step refills the output register, so it waits for a free slot.
  always_comb begin
    step = 1'b0;
    unique case (st_q)
      ST_INIT, ST_DISC: step = !ph_q;
      ST_RUN:           step = !ph_q && (!mv_q || m_ready);
      default:          step = 1'b0;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    lfsr_d = lfsr_q;
    r1_d   = r1_q;
    r2_d   = r2_q;
    cnt_d  = cnt_q;
    ph_d   = ph_q;
    z_d    = z_q;
    mv_d   = mv_q;
    if (mv_q && m_ready) mv_d = 1'b0;
    if (step) begin
      lfsr_d = {s16, lfsr_q[15:1]};
      if (sbox_sync) begin
        ph_d = 1'b1;
      end else begin
        r1_d = su;
        r2_d = sv;
      end
      unique case (st_q)
        ST_INIT: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == LAST_RND) st_d = ST_DISC;
        end
        ST_DISC: st_d = ST_RUN;
        ST_RUN: begin
          z_d  = w ^ x3;
          mv_d = 1'b1;
        end
        default: st_d = st_q;
      endcase
    end
    if (ph_q) begin
      r1_d = su;
      r2_d = sv;
      ph_d = 1'b0;
    end
    if (load) begin
      lfsr_d = lfsr_ld;
      r1_d   = 32'd0;
      r2_d   = 32'd0;
      cnt_d  = 5'd0;
      ph_d   = 1'b0;
      mv_d   = 1'b0;
      st_d   = ST_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      lfsr_q <= '0;
      r1_q   <= 32'd0;
      r2_q   <= 32'd0;
      cnt_q  <= 5'd0;
      ph_q   <= 1'b0;
      z_q    <= 32'd0;
      mv_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      lfsr_q <= lfsr_d;
      r1_q   <= r1_d;
      r2_q   <= r2_d;
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      z_q    <= z_d;
      mv_q   <= mv_d;
    end
  end

endmodule

// File: tb/tb_zuc_keystream_gen.sv
// Bench for zuc_keystream_gen: both S-box timing variants, random
// consumer backpressure, scoreboard of expected keystream words.
module tb_zuc_keystream_gen;

  typedef struct {
    logic [127:0] key;
    logic [127:0] iv;
    logic [31:0]  z0;
    logic [31:0]  z1;
    logic [31:0]  zl;
    bit           has_l;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    bit          chk;
    int          idx;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         s_valid [2];
  logic         s_ready [2];
  logic         s_init  [2];
  logic [127:0] skey    [2];
  logic [127:0] siv     [2];
  logic         mv      [2];
  logic         mr      [2];
  logic [31:0]  mdat    [2];

  int          cur;
  int          cmode;
  int          ncmp;
  int          nfail;
  int          hs_tot;
  int          stab_err;
  bit          hold_v;
  logic [31:0] hold_d;
  vec_t        tv [4];
  exp_t        sbq [$];
  logic [31:0] obs [$];

  zuc_keystream_gen #(
    .sbox_sync (1'b0)
  ) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid[0]),
    .s_ready (s_ready[0]),
    .s_init  (s_init[0]),
    .s_key   (skey[0]),
    .s_iv    (siv[0]),
    .m_valid (mv[0]),
    .m_ready (mr[0]),
    .m_data  (mdat[0])
  );

  zuc_keystream_gen #(
    .sbox_sync (1'b1)
  ) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid[1]),
    .s_ready (s_ready[1]),
    .s_init  (s_init[1]),
    .s_key   (skey[1]),
    .s_iv    (siv[1]),
    .m_valid (mv[1]),
    .m_ready (mr[1]),
    .m_data  (mdat[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer: picks m_ready for the coming edge, logs accepted words.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (d != cur) mr[d] = 1'b0;
    if (hold_v && cmode != 0 && (!mv[cur] || mdat[cur] != hold_d))
      stab_err++;
    if (cmode == 2) mr[cur] = 1'b1;
    else if (cmode == 1) mr[cur] = ($urandom_range(1, 0) != 0);
    else mr[cur] = 1'b0;
    hold_v = (cmode != 0) && mv[cur] && !mr[cur];
    hold_d = mdat[cur];
    if (mv[cur] && mr[cur]) begin
      obs.push_back(mdat[cur]);
      hs_tot++;
    end
  end

  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[127-8*i -: 8];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_le(input string nm, input int got, input int lim);
    ncmp++;
    if (got > lim) begin
      nfail++;
      $display("FAIL %s: got %0d want <= %0d", nm, got, lim);
    end
  endtask

  task automatic push_vec(input int v, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx = i;
      e.chk = 1'b1;
      if (i == 0) e.val = tv[v].z0;
      else if (i == 1) e.val = tv[v].z1;
      else if (i == 1999 && tv[v].has_l) e.val = tv[v].zl;
      else begin
        e.val = 32'd0;
        e.chk = 1'b0;
      end
      sbq.push_back(e);
    end
  endtask

  task automatic send_cmd(input int d, input bit ini,
                          input logic [127:0] k, input logic [127:0] iv);
    bit acc;
    int c;
    acc = 1'b0;
    c = 0;
    s_valid[d] = 1'b1;
    s_init[d]  = ini;
    skey[d]    = k;
    siv[d]     = iv;
    while (!acc && c < 200) begin
      @(negedge clk);
      acc = s_ready[d];
      @(posedge clk);
      #1;
      c++;
    end
    s_valid[d] = 1'b0;
    s_init[d]  = 1'b0;
    if (!acc) begin
      ncmp++;
      nfail++;
      $display("FAIL cmd_accept: got 0 want 1");
    end
  endtask

  task automatic drain(input int stop);
    int          c;
    exp_t        e;
    logic [31:0] o;
    c = 0;
    while (sbq.size() > stop && c < 20000) begin
      @(posedge clk);
      c++;
      while (obs.size() > 0 && sbq.size() > 0) begin
        o = obs.pop_front();
        e = sbq.pop_front();
        if (e.chk) check($sformatf("z[%0d]", e.idx), o, e.val);
      end
    end
    if (sbq.size() > stop) begin
      ncmp++;
      nfail++;
      $display("FAIL drain_timeout: left %0d want <= %0d",
               sbq.size(), stop);
    end
    #1 cmode = 0;
  endtask

  task automatic start(input int d, input int v, input int n);
    int lat;
    push_vec(v, n);
    send_cmd(d, 1'b1, tv[v].key, tv[v].iv);
    check("s_ready_busy", 32'(s_ready[d]), 32'd0);
    check("m_valid_clr", 32'(mv[d]), 32'd0);
    lat = 0;
    while (!mv[d] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk_le("latency", lat, (d != 0) ? 80 : 40);
    @(posedge clk);
    #1 cmode = 1;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int h0;
    tv[0] = '{128'h0, 128'h0, 32'h27bede74, 32'h018082da,
              32'h0, 1'b0};
    tv[1] = '{{128{1'b1}}, {128{1'b1}}, 32'h0657cfa0,
              32'h7096398b, 32'h0, 1'b0};
    tv[2] = '{brev(128'h3d4c4be96a82fdaeb58f641db17b455b),
              brev(128'h84319aa8de6915ca1f6bda6bfbd8c766),
              32'h14f1c272, 32'h3279c419, 32'h0, 1'b0};
    tv[3] = '{brev(128'h4d320bfad4c285bfd6b8bd00f39d8b41),
              brev(128'h52959daba0bf176ece2dc315049eb574),
              32'hed4400e7, 32'h0633e5c5, 32'h7a574cdb, 1'b1};
    ncmp = 0;
    nfail = 0;
    hs_tot = 0;
    stab_err = 0;
    hold_v = 1'b0;
    hold_d = 32'd0;
    cur = 0;
    cmode = 0;
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0;
      s_init[d]  = 1'b0;
      skey[d]    = '0;
      siv[d]     = '0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      cur = d;
      pulse_rst();
      check("rst_s_ready", 32'(s_ready[d]), 32'd1);
      check("rst_m_valid", 32'(mv[d]), 32'd0);

      for (int v = 0; v < 3; v++) begin
        start(d, v, 2);
        drain(0);
      end

      start(d, 3, 2000);
      drain(1000);
      cmode = 1;
      send_cmd(d, 1'b0, '0, '0);
      check("noop_ready", 32'(s_ready[d]), 32'd1);
      drain(500);
      cmode = 2;
      repeat (6) @(posedge clk);
      h0 = hs_tot;
      repeat (40) @(posedge clk);
      check("throughput", 32'(hs_tot - h0), (d != 0) ? 32'd20 : 32'd40);
      cmode = 1;
      drain(0);

      start(d, 3, 2000);
      drain(1990);
      repeat (2) @(posedge clk);
      #1;
      sbq.delete();
      obs.delete();
      start(d, 0, 2);
      drain(0);

      send_cmd(d, 1'b1, tv[1].key, tv[1].iv);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("midrst_m_valid", 32'(mv[d]), 32'd0);
      check("midrst_s_ready", 32'(s_ready[d]), 32'd1);
      start(d, 2, 2);
      drain(0);
    end

    check("stable_hold", 32'(stab_err), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
